// File: rtl/apb_master.sv
// APB master: turns a valid/ready command into a single APB SETUP/ACCESS transfer
// and reports completion (or wait-state timeout) as a one-cycle response pulse.
module apb_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   localparam logic [7:0] L_TMO = 8'(TIMEOUT);

   state_t            r_state;
   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_timeout;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [7:0]        r_wait_cnt;

   logic [7:0]        w_cnt_nxt;
   logic              w_tmo_hit;

   assign w_cnt_nxt = r_wait_cnt + 8'd1;
   assign w_tmo_hit = (w_cnt_nxt == L_TMO);

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state       <= S_IDLE;
         r_cmd_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_timeout <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_wait_cnt    <= '0;
      end else begin
         // response flags are single-cycle pulses
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_pwrite    <= cmd_write;
                  r_paddr     <= cmd_addr;
                  r_pwdata    <= cmd_wdata;
                  r_psel      <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable  <= 1'b1;
               r_wait_cnt <= '0;
               r_state    <= S_ACCESS;
            end
            S_ACCESS: begin
               // pready is checked first so a ready on the timeout edge still completes
               if (pready) begin
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_pwrite ? '0 : prdata;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_wait_cnt <= w_cnt_nxt;
                  if (w_tmo_hit) begin
                     r_psel        <= 1'b0;
                     r_penable     <= 1'b0;
                     r_rsp_valid   <= 1'b1;
                     r_rsp_timeout <= 1'b1;
                     r_rsp_rdata   <= '0;
                     r_cmd_ready   <= 1'b1;
                     r_state       <= S_IDLE;
                  end
               end
            end
            default: begin
               r_psel      <= 1'b0;
               r_penable   <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_timeout = r_rsp_timeout;
   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign paddr       = r_paddr;
   assign pwdata      = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a behavioural APB slave with programmable wait states and
// a transaction-level model predicting latency, response data and timeouts.
module tb_apb_master;

   localparam int TMO = 16;

   logic        pclk = 1'b0;
   logic        preset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, rsp_cnt = 0;
   int slv_waits = 0;
   int slv_k = 0;
   bit slv_in_acc = 0;
   logic [31:0] smem [256];
   logic [31:0] mmem [256];

   typedef struct packed {
      logic [7:0]  lat;    // ticks from handshake edge to response cycle
      logic [7:0]  acc;    // ACCESS cycles observed
      logic [31:0] rd;
      logic        to;
      logic [4:0]  flags;  // setup ok, stable, ready low, done clean, held after done
   } res_t;

   apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;
   always @(negedge pclk) if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;

   function automatic logic [31:0] init_val(input int i);
      return 32'(i) * 32'h9E37_79B1;
   endfunction

   // Slave: completes on the (slv_waits+1)-th ACCESS cycle; junk on pready/prdata elsewhere
   initial begin
      for (int i = 0; i < 256; i++) smem[i] = init_val(i);
      pready = 1'b0;
      prdata = '0;
      forever begin
         @(posedge pclk);
         if (psel === 1'b1 && penable === 1'b1 && pready === 1'b1 && pwrite === 1'b1)
            smem[paddr] = pwdata;
         #1;
         if (psel === 1'b1 && penable === 1'b1) begin
            slv_k      = slv_in_acc ? slv_k + 1 : 0;
            slv_in_acc = 1'b1;
            pready     = (slv_k >= slv_waits);
            prdata     = smem[paddr];
         end else begin
            slv_in_acc = 1'b0;
            pready     = 1'($urandom_range(0, 1));
            prdata     = $urandom;
         end
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // Reference: a transfer takes one SETUP plus min(waits+1, TMO) ACCESS cycles
   function automatic res_t expect_xfer(input logic wr, input logic [7:0] a,
                                        input logic [31:0] d, input int waits);
      res_t e;
      int   n;
      if (waits < TMO) begin
         n    = waits + 1;
         e.to = 1'b0;
         e.rd = wr ? 32'h0 : mmem[a];
         if (wr) mmem[a] = d;
      end else begin
         n    = TMO;
         e.to = 1'b1;
         e.rd = 32'h0;
      end
      e.lat   = 8'(n + 1);
      e.acc   = 8'(n);
      e.flags = 5'b11111;
      return e;
   endfunction

   // Drives one command and measures what the DUT did; returns at the response cycle
   task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input int waits, input bit keep, output res_t r, output int hs);
      int g, lat, acc;
      bit stable, rlow, setup_ok;
      slv_waits = waits;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      g = 0;
      while (cmd_ready !== 1'b1 && g < 20) begin tick(); g++; end
      tick();
      hs = cyc;
      if (!keep) cmd_valid = 1'b0;
      setup_ok = (psel === 1'b1 && penable === 1'b0);
      lat = 0; acc = 0; stable = 1; rlow = 1;
      while (rsp_valid !== 1'b1 && lat < 300) begin
         if (psel === 1'b1 && penable === 1'b1) acc++;
         if (psel !== 1'b1 || pwrite !== wr || paddr !== a || pwdata !== d) stable = 0;
         if (cmd_ready !== 1'b0) rlow = 0;
         tick();
         lat++;
      end
      r.lat   = 8'(lat);
      r.acc   = 8'(acc);
      r.rd    = rsp_rdata;
      r.to    = rsp_timeout;
      r.flags = {setup_ok, stable, rlow,
                 (psel === 1'b0 && penable === 1'b0 && cmd_ready === 1'b1),
                 (pwrite === wr && paddr === a && pwdata === d)};
   endtask

   task automatic test_reset();
      preset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 8'h5A; cmd_wdata = 32'h1234_5678;
      tick(); tick();
      n_chk++;
      if ({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_timeout} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 100000",
                  {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_timeout});
      end
      n_chk++;
      if ({paddr, pwdata, rsp_rdata} !== 72'h0) begin
         n_fail++;
         $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h expected all 0",
                  paddr, pwdata, rsp_rdata);
      end
      cmd_valid = 1'b0; preset = 1'b0;
      tick();
   endtask

   task automatic test_idle();
      int n0 = rsp_cnt;
      bit bad = 0;
      cmd_valid = 1'b0;
      repeat (5) begin
         tick();
         if (psel !== 1'b0 || cmd_ready !== 1'b1) bad = 1;
      end
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL idle_bus: got activity while idle, expected psel=0 cmd_ready=1"); end
      n_chk++;
      if (rsp_cnt !== n0) begin n_fail++; $display("FAIL idle_rsp: got %0d responses expected 0", rsp_cnt - n0); end
   endtask

   task automatic test_write_read();
      res_t r, e;
      int   hs;
      run_cmd(1'b1, 8'h04, 32'hDEAD_BEEF, 0, 1'b0, r, hs);
      e = expect_xfer(1'b1, 8'h04, 32'hDEAD_BEEF, 0);
      n_chk++;
      if (r !== e) begin
         n_fail++;
         $display("FAIL write04: got lat=%0d acc=%0d rd=%h to=%b fl=%b expected lat=%0d acc=%0d rd=%h to=%b fl=%b",
                  r.lat, r.acc, r.rd, r.to, r.flags, e.lat, e.acc, e.rd, e.to, e.flags);
      end
      tick();
      run_cmd(1'b0, 8'h04, 32'h0, 0, 1'b0, r, hs);
      e = expect_xfer(1'b0, 8'h04, 32'h0, 0);
      n_chk++;
      if (r !== e || r.rd !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL read04: got lat=%0d acc=%0d rd=%h to=%b fl=%b expected lat=%0d acc=%0d rd=deadbeef to=%b fl=%b",
                  r.lat, r.acc, r.rd, r.to, r.flags, e.lat, e.acc, e.to, e.flags);
      end
      tick();
   endtask

   task automatic test_wait_states();
      res_t r, e;
      int   hs, n0;
      n0 = rsp_cnt;
      run_cmd(1'b1, 8'h21, 32'hCAFE_F00D, 3, 1'b0, r, hs);
      e = expect_xfer(1'b1, 8'h21, 32'hCAFE_F00D, 3);
      tick(); tick();
      n_chk++;
      if (r !== e) begin
         n_fail++;
         $display("FAIL wait3: got lat=%0d acc=%0d rd=%h to=%b fl=%b expected lat=%0d acc=%0d rd=%h to=%b fl=%b",
                  r.lat, r.acc, r.rd, r.to, r.flags, e.lat, e.acc, e.rd, e.to, e.flags);
      end
      n_chk++;
      if (rsp_cnt - n0 !== 1) begin n_fail++; $display("FAIL wait3_pulses: got %0d expected 1", rsp_cnt - n0); end
   endtask

   task automatic test_timeout();
      res_t r, e;
      int   hs;
      // waits: ready on the last allowed cycle, never ready (read and write), then read-back
      int   wt [4] = '{TMO - 1, 1000, 1000, 0};
      logic wr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         run_cmd(wr[i], 8'h40, 32'h0BAD_0000 + 32'(i), wt[i], 1'b0, r, hs);
         e = expect_xfer(wr[i], 8'h40, 32'h0BAD_0000 + 32'(i), wt[i]);
         n_chk++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL timeout_%0d: got lat=%0d acc=%0d rd=%h to=%b fl=%b expected lat=%0d acc=%0d rd=%h to=%b fl=%b",
                     i, r.lat, r.acc, r.rd, r.to, r.flags, e.lat, e.acc, e.rd, e.to, e.flags);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      res_t r, e;
      int   hs [4];
      int   n0 = rsp_cnt;
      bit   gap_ok = 1;
      for (int i = 0; i < 4; i++) begin
         run_cmd(1'b0, 8'(8'h80 + 8'(i)), $urandom, 0, 1'b1, r, hs[i]);
         e = expect_xfer(1'b0, 8'(8'h80 + 8'(i)), 32'h0, 0);
         r.flags[0] = 1'b1; // wdata is random here, held-value check is covered elsewhere
         r.flags[3] = 1'b1;
         n_chk++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL b2b_%0d: got lat=%0d acc=%0d rd=%h to=%b fl=%b expected lat=%0d acc=%0d rd=%h to=%b",
                     i, r.lat, r.acc, r.rd, r.to, r.flags, e.lat, e.acc, e.rd, e.to);
         end
      end
      cmd_valid = 1'b0;
      tick();
      for (int i = 1; i < 4; i++) if (hs[i] - hs[i-1] != 3) gap_ok = 0;
      n_chk++;
      if (!gap_ok) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d %0d %0d expected 3 3 3",
                  hs[1] - hs[0], hs[2] - hs[1], hs[3] - hs[2]);
      end
      n_chk++;
      if (rsp_cnt - n0 !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", rsp_cnt - n0); end
   endtask

   task automatic test_reset_access();
      int n0;
      slv_waits = 1000;
      cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 32'h7777_1111; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();
      n_chk++;
      if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_access: got %b expected 11", {psel, penable}); end
      n0 = rsp_cnt;
      preset = 1'b1; cmd_valid = 1'b1;
      tick();
      n_chk++;
      if ({psel, penable, cmd_ready, rsp_valid, paddr} !== {4'b0010, 8'h00}) begin
         n_fail++;
         $display("FAIL rst_abort: got psel=%b pen=%b rdy=%b rsp=%b paddr=%h expected 0 0 1 0 00",
                  psel, penable, cmd_ready, rsp_valid, paddr);
      end
      tick();
      n_chk++;
      if (psel !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept: got psel=%b expected 0", psel); end
      preset = 1'b0; cmd_valid = 1'b0;
      tick(); tick();
      n_chk++;
      if (rsp_cnt !== n0) begin n_fail++; $display("FAIL rst_no_rsp: got %0d responses expected 0", rsp_cnt - n0); end
   endtask

   task automatic test_random();
      res_t r, e;
      int   hs, w, sel, n0;
      logic wr;
      logic [7:0]  a;
      logic [31:0] d;
      n0 = rsp_cnt;
      for (int i = 0; i < 40; i++) begin
         wr  = 1'($urandom_range(0, 1));
         a   = 8'($urandom_range(0, 15));
         d   = $urandom;
         sel = $urandom_range(0, 9);
         w   = (sel < 6) ? $urandom_range(0, 3) : (sel < 8) ? $urandom_range(TMO - 2, TMO) : 100;
         run_cmd(wr, a, d, w, 1'b0, r, hs);
         e = expect_xfer(wr, a, d, w);
         n_chk++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL rand_%0d (wr=%b a=%h w=%0d): got lat=%0d acc=%0d rd=%h to=%b fl=%b expected lat=%0d acc=%0d rd=%h to=%b fl=%b",
                     i, wr, a, w, r.lat, r.acc, r.rd, r.to, r.flags, e.lat, e.acc, e.rd, e.to, e.flags);
         end
         repeat ($urandom_range(1, 3)) tick();
      end
      n_chk++;
      if (rsp_cnt - n0 !== 40) begin n_fail++; $display("FAIL rand_pulses: got %0d expected 40", rsp_cnt - n0); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
      preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      test_reset();
      test_idle();
      test_write_read();
      test_wait_states();
      test_timeout();
      test_back_to_back();
      test_reset_access();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
